// File: rtl/fb_axi_wr_ctrl_if.sv
// FIFO-side and AXI write-channel signals of the frame-buffer write stage.
// master = write controller, slave = FIFO/DDR side.
interface fb_axi_wr_ctrl_if;
  logic [127:0] fifo_rdata;
  logic [9:0]   fifo_rd_count;
  logic         fifo_rd_en;

  logic [31:0]  axi_awaddr;
  logic [7:0]   axi_awlen;
  logic [2:0]   axi_awsize;
  logic [1:0]   axi_awburst;
  logic         axi_awvalid;
  logic         axi_awready;

  logic [127:0] axi_wdata;
  logic [15:0]  axi_wstrb;
  logic         axi_wlast;
  logic         axi_wvalid;
  logic         axi_wready;

  logic [1:0]   axi_bresp;
  logic         axi_bvalid;
  logic         axi_bready;

  modport master (
    input  fifo_rdata, fifo_rd_count, axi_awready, axi_wready, axi_bresp, axi_bvalid,
    output fifo_rd_en, axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awvalid,
           axi_wdata, axi_wstrb, axi_wlast, axi_wvalid, axi_bready
  );

  modport slave (
    output fifo_rdata, fifo_rd_count, axi_awready, axi_wready, axi_bresp, axi_bvalid,
    input  fifo_rd_en, axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awvalid,
           axi_wdata, axi_wstrb, axi_wlast, axi_wvalid, axi_bready
  );
endinterface

// File: rtl/fb_axi_wr_ctrl.sv
// Frame-buffer write stage: drains a FWFT line FIFO into DDR as fixed-length
// AXI INCR bursts, one burst outstanding at a time, wrapping once per frame.
//
// state       | meaning
// S_IDLE      | waiting for DDR calibration (init flag)
// S_WAIT_DATA | waiting for a full burst worth of words in the FIFO
// S_WR_ADDR   | AW valid, address held until accepted
// S_WR_DATA   | streaming beats, wvalid held high
// S_WR_RESP   | bready high, waiting for the B response
module fb_axi_wr_ctrl #(
  parameter logic [31:0] START_ADDR   = 32'h0020_0000,
  parameter int unsigned BURST_BEATS  = 64,
  parameter int unsigned ADDR_INC     = 1024,
  parameter int unsigned FRAME_BURSTS = 1800
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ddr_init_done,
  fb_axi_wr_ctrl_if.master bus,
  output logic             frame_done,
  output logic             wr_err
);

  localparam int unsigned BW = (BURST_BEATS > 2) ? $clog2(BURST_BEATS) : 1;
  localparam int unsigned IW = (FRAME_BURSTS > 2) ? $clog2(FRAME_BURSTS) : 1;

  localparam logic [BW-1:0] C_BEAT_PRE = BW'(BURST_BEATS - 2);
  localparam logic [IW-1:0] C_IDX_LAST = IW'(FRAME_BURSTS - 1);
  localparam logic [9:0]    C_CNT_MIN  = 10'(BURST_BEATS);
  localparam logic [31:0]   C_INC      = 32'(ADDR_INC);
  localparam logic [7:0]    C_AWLEN    = 8'(BURST_BEATS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_DATA,
    S_WR_ADDR,
    S_WR_DATA,
    S_WR_RESP
  } t_state;

  t_state        r_state;
  logic          r_init;
  logic [31:0]   r_awaddr;
  logic [IW-1:0] r_idx;
  logic [BW-1:0] r_beat;
  logic          r_awvalid;
  logic          r_wvalid;
  logic          r_wlast;
  logic          r_bready;
  logic          r_frame_done;
  logic          r_wr_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_init       <= 1'b0;
      r_awaddr     <= START_ADDR;
      r_idx        <= '0;
      r_beat       <= '0;
      r_awvalid    <= 1'b0;
      r_wvalid     <= 1'b0;
      r_wlast      <= 1'b0;
      r_bready     <= 1'b0;
      r_frame_done <= 1'b0;
      r_wr_err     <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (ddr_init_done) r_init <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (r_init) r_state <= S_WAIT_DATA;
        end
        S_WAIT_DATA: begin
          if (bus.fifo_rd_count >= C_CNT_MIN) begin
            r_awvalid <= 1'b1;
            r_state   <= S_WR_ADDR;
          end
        end
        S_WR_ADDR: begin
          if (bus.axi_awready) begin
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b1;
            r_state   <= S_WR_DATA;
          end
        end
        S_WR_DATA: begin
          // wvalid is always high here, so wready alone marks a beat
          if (bus.axi_wready) begin
            if (r_wlast) begin
              r_wvalid <= 1'b0;
              r_wlast  <= 1'b0;
              r_beat   <= '0;
              r_bready <= 1'b1;
              r_state  <= S_WR_RESP;
            end else begin
              r_beat  <= r_beat + 1'b1;
              r_wlast <= (r_beat == C_BEAT_PRE);
            end
          end
        end
        S_WR_RESP: begin
          if (bus.axi_bvalid) begin
            r_bready <= 1'b0;
            r_state  <= S_WAIT_DATA;
            if (bus.axi_bresp != 2'b00) r_wr_err <= 1'b1;
            if (r_idx == C_IDX_LAST) begin
              r_awaddr     <= START_ADDR;
              r_idx        <= '0;
              r_frame_done <= 1'b1;
            end else begin
              r_awaddr <= r_awaddr + C_INC;
              r_idx    <= r_idx + 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.fifo_rd_en  = r_wvalid & bus.axi_wready;
  assign bus.axi_awaddr  = r_awaddr;
  assign bus.axi_awlen   = C_AWLEN;
  assign bus.axi_awsize  = 3'b100;
  assign bus.axi_awburst = 2'd1;
  assign bus.axi_awvalid = r_awvalid;
  assign bus.axi_wdata   = bus.fifo_rdata;
  assign bus.axi_wstrb   = 16'hFFFF;
  assign bus.axi_wlast   = r_wlast;
  assign bus.axi_wvalid  = r_wvalid;
  assign bus.axi_bready  = r_bready;
  assign frame_done      = r_frame_done;
  assign wr_err          = r_wr_err;

endmodule

// File: tb/tb_fb_axi_wr_ctrl.sv
// Bench for fb_axi_wr_ctrl: directed sequence with random stalls and data,
// checked against a burst-level model (address, frame pulse, sticky error).
module tb_fb_axi_wr_ctrl;
  localparam logic [31:0] START = 32'h0020_0000;
  localparam int BEATS = 64;
  localparam int INC   = 1024;
  localparam int FB    = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ddr_init_done = 1'b0;
  logic frame_done;
  logic wr_err;

  fb_axi_wr_ctrl_if bus();

  fb_axi_wr_ctrl #(
    .START_ADDR(START), .BURST_BEATS(BEATS), .ADDR_INC(INC), .FRAME_BURSTS(FB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ddr_init_done(ddr_init_done),
    .bus(bus), .frame_done(frame_done), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int burst_no = 0;
  logic err_model = 1'b0;
  logic [127:0] cur_word;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_addr();
    return START + 32'((burst_no % FB) * INC);
  endfunction

  task automatic new_word();
    cur_word = {$urandom, $urandom, $urandom, $urandom};
    bus.fifo_rdata = cur_word;
  endtask

  task automatic do_aw(input int stall_pct);
    bit got = 0;
    bit seen = 0;
    int cyc = 0;
    while (!got && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (seen) chk("awvalid_hold", bus.axi_awvalid, 1);
      if (bus.axi_awvalid) begin
        seen = 1;
        chk("awaddr", bus.axi_awaddr, exp_addr());
        chk("aw_w_excl", bus.axi_wvalid, 0);
        chk("frame_done_idle", frame_done, 0);
        if ($urandom_range(99) >= stall_pct) begin
          bus.axi_awready = 1'b1;
          got = 1;
        end else begin
          bus.axi_awready = 1'b0;
        end
      end
    end
    chk("aw_seen", got, 1);
    chk("awlen", bus.axi_awlen, 63);
    chk("awsize", bus.axi_awsize, 3'b100);
    chk("awburst", bus.axi_awburst, 2'd1);
    chk("wstrb", bus.axi_wstrb, 16'hFFFF);
    @(negedge clk);
    bus.axi_awready = 1'b0;
    chk("awvalid_drop", bus.axi_awvalid, 0);
    chk("wvalid_lat", bus.axi_wvalid, 1);
  endtask

  task automatic do_w(input int stall_pct);
    int beats = 0;
    int lasts = 0;
    int pops = 0;
    int cyc = 0;
    while (beats < BEATS && cyc < 3000) begin
      cyc++;
      bus.axi_wready = ($urandom_range(99) >= stall_pct);
      #1;
      chk("wvalid", bus.axi_wvalid, 1);
      chk("aw_w_excl_d", bus.axi_awvalid, 0);
      chk("wlast", bus.axi_wlast, (beats == BEATS - 1));
      chk("rd_en", bus.fifo_rd_en, bus.axi_wready);
      if (bus.axi_wready) begin
        chk("wdata", bus.axi_wdata, cur_word);
        beats++;
        if (bus.axi_wlast) lasts++;
        if (bus.fifo_rd_en) pops++;
      end
      @(negedge clk);
      if (bus.axi_wready) new_word();
    end
    bus.axi_wready = 1'b0;
    chk("beats", beats, BEATS);
    chk("wlast_cnt", lasts, 1);
    chk("pops", pops, BEATS);
  endtask

  task automatic do_b(input logic [1:0] resp);
    logic exp_fd;
    chk("wvalid_off", bus.axi_wvalid, 0);
    chk("bready", bus.axi_bready, 1);
    repeat ($urandom_range(3)) begin
      @(negedge clk);
      chk("bready_hold", bus.axi_bready, 1);
    end
    bus.axi_bvalid = 1'b1;
    bus.axi_bresp  = resp;
    @(negedge clk);
    bus.axi_bvalid = 1'b0;
    bus.axi_bresp  = 2'b00;
    exp_fd = ((burst_no % FB) == FB - 1);
    if (resp != 2'b00) err_model = 1'b1;
    burst_no++;
    chk("bready_off", bus.axi_bready, 0);
    chk("frame_done", frame_done, exp_fd);
    chk("wr_err", wr_err, err_model);
    chk("aw_gap", bus.axi_awvalid, 0);
    @(negedge clk);
    chk("frame_done_pulse", frame_done, 0);
  endtask

  initial begin
    bit seen;
    bus.fifo_rd_count = 10'd200;
    bus.axi_awready   = 1'b0;
    bus.axi_wready    = 1'b0;
    bus.axi_bvalid    = 1'b0;
    bus.axi_bresp     = 2'b00;
    new_word();

    repeat (3) @(negedge clk);
    chk("rst_awvalid", bus.axi_awvalid, 0);
    chk("rst_wvalid", bus.axi_wvalid, 0);
    chk("rst_wlast", bus.axi_wlast, 0);
    chk("rst_bready", bus.axi_bready, 0);
    chk("rst_rd_en", bus.fifo_rd_en, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_wr_err", wr_err, 0);
    chk("rst_awaddr", bus.axi_awaddr, START);
    rst_n = 1'b1;

    // no activity before DDR calibration
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("no_aw_before_init", bus.axi_awvalid, 0);
    end
    ddr_init_done = 1'b1;
    seen = 0;
    for (int i = 0; i < 3 && !seen; i++) begin
      @(negedge clk);
      if (bus.axi_awvalid) seen = 1;
    end
    chk("init_latency", seen, 1);

    do_aw(0);
    do_w(0);
    bus.fifo_rd_count = 10'd63;
    do_b(2'b00);

    // 63 words is one short of a burst
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("no_aw_at_63", bus.axi_awvalid, 0);
    end
    bus.fifo_rd_count = 10'd64;
    ddr_init_done = 1'b0;
    @(negedge clk);
    chk("aw_at_64", bus.axi_awvalid, 1);
    do_aw(0);
    do_w(0);
    bus.fifo_rd_count = 10'd200;
    do_b(2'b00);

    // stalled bursts across two frame wraps, one SLVERR response
    for (int b = 0; b < 8; b++) begin
      do_aw(50);
      do_w(50);
      do_b((burst_no == 2) ? 2'b10 : 2'b00);
    end

    // asynchronous reset in the middle of a burst
    do_aw(0);
    bus.axi_wready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      new_word();
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_awvalid", bus.axi_awvalid, 0);
    chk("mid_rst_wvalid", bus.axi_wvalid, 0);
    chk("mid_rst_wlast", bus.axi_wlast, 0);
    chk("mid_rst_bready", bus.axi_bready, 0);
    chk("mid_rst_rd_en", bus.fifo_rd_en, 0);
    chk("mid_rst_frame_done", frame_done, 0);
    chk("mid_rst_wr_err", wr_err, 0);
    chk("mid_rst_awaddr", bus.axi_awaddr, START);
    bus.axi_wready = 1'b0;
    burst_no = 0;
    err_model = 1'b0;
    ddr_init_done = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int b = 0; b < 2; b++) begin
      do_aw(50);
      do_w(50);
      do_b(2'b00);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fb_axi_wr_ctrl.md
Name: fb_axi_wr_ctrl

Overview:
- Frame-buffer write stage. Drains 128-bit pixel words from a show-ahead (FWFT) line FIFO and writes them to DDR over the AXI write channels (AW/W/B) as fixed 64-beat INCR bursts.
- Sits directly upstream of the HDMI frame-buffer read controller and fills the same DDR region that controller scans. Address layout, burst size and frame size match the read side so one written frame is exactly one displayed frame.

Parameters:
- START_ADDR, 32'h00200000, byte address of the first burst of the frame.
- BURST_BEATS, 64, beats per burst; awlen = BURST_BEATS-1.
- ADDR_INC, 1024, byte address step per burst (BURST_BEATS x 16 bytes).
- FRAME_BURSTS, 1800, bursts per frame (1800 for 1280x720, 600 for 640x480).

Ports:
- clk  in  1  system/AXI clock.
- rst_n  in  1  asynchronous active-low reset.
- ddr_init_done  in  1  DDR calibration complete; sticky once seen high.
- fifo_rdata  in  128  FWFT FIFO head word.
- fifo_rd_count  in  10  words currently in FIFO.
- fifo_rd_en  out  1  pops FIFO head.
- axi_awaddr  out  32  burst address.
- axi_awlen  out  8  constant BURST_BEATS-1.
- axi_awsize  out  3  constant 3'b100.
- axi_awburst  out  2  constant 2'd1 (INCR).
- axi_awvalid  out  1  address valid.
- axi_awready  in  1  address accepted.
- axi_wdata  out  128  equals fifo_rdata.
- axi_wstrb  out  16  constant 16'hFFFF.
- axi_wlast  out  1  final beat of burst.
- axi_wvalid  out  1  data valid.
- axi_wready  in  1  data accepted.
- axi_bresp  in  2  write response.
- axi_bvalid  in  1  response valid.
- axi_bready  out  1  response ready.
- frame_done  out  1  one-cycle pulse when the last burst of a frame is acknowledged.
- wr_err  out  1  sticky; set when any bresp != 2'b00.

Behaviour:
- Reset values: awvalid, wvalid, wlast, bready, fifo_rd_en, frame_done and wr_err = 0; awaddr = START_ADDR; burst index = 0; beat counter = 0; state = IDLE. Reset is asynchronous and takes effect mid-burst; no burst completion is attempted.
- init flag: set on ddr_init_done = 1 and cleared only by reset.
- States:
  - IDLE -> WAIT_DATA when the init flag is set.
  - WAIT_DATA -> WR_ADDR when fifo_rd_count >= BURST_BEATS.
  - WR_ADDR: awvalid = 1, held with address stable until awready. The handshake cycle (awvalid & awready) moves to WR_DATA and deasserts awvalid on the next cycle.
  - WR_DATA: wvalid = 1 on every cycle in this state. fifo_rd_en = wvalid & wready, combinational. The beat counter increments on each handshake. wlast = 1 when the beat counter = BURST_BEATS-1. A handshake with wlast moves to WR_RESP and clears the beat counter. No bubbles are inserted, because 64 words were guaranteed at entry.
  - WR_RESP: bready = 1. On bvalid, return to WAIT_DATA and update state:
    - If bresp != 0, set wr_err.
    - If burst index = FRAME_BURSTS-1: awaddr <= START_ADDR, burst index <= 0, frame_done = 1 for the next cycle.
    - Otherwise: awaddr <= awaddr + ADDR_INC, burst index + 1.
- The address advances only after the B response, so exactly one burst is outstanding at any time.
- awvalid and wvalid are never asserted together; W never precedes AW.
- Last frame address = START_ADDR + (FRAME_BURSTS-1)*ADDR_INC. Wrap is exact, with no address past this value.
- fifo_rd_count exactly = BURST_BEATS qualifies; BURST_BEATS-1 does not.
- ddr_init_done dropping after it was set has no effect.
- Latency:
  - WAIT_DATA qualifying -> awvalid = 1 cycle.
  - awready handshake -> first wvalid = 1 cycle.
  - B handshake -> next awvalid >= 2 cycles.

Test Plan:
- Hold ddr_init_done = 0 with fifo_rd_count = 200 for 100 cycles -> awvalid stays 0. Raise ddr_init_done -> awvalid within 3 cycles, awaddr = 32'h00200000, awlen = 63.
- Set fifo_rd_count = 63 -> no AW. Step to 64 -> AW issued. Next, 64 W beats with wready always 1 -> exactly 64 fifo_rd_en pulses, wlast only on beat 64, wdata tracks fifo_rdata.
- Random wready and awready stalls (50%) -> awaddr and awvalid held stable while stalled. Exactly 64 beats and one wlast per burst. Second burst awaddr = 32'h00200400.
- FRAME_BURSTS = 4 with continuous data -> addresses 0x00200000, 0x00200400, 0x00200800, 0x00200C00, then 0x00200000. frame_done pulses once, 1 cycle, after the 4th bvalid.
- bresp = 2'b10 on burst 2 -> wr_err set and stays 1 through later OKAY responses, until reset.
- Assert rst_n = 0 at beat 30 of a burst -> all outputs 0 immediately. After release with data available -> restarts at 32'h00200000, beat counter 0.
